// File: rtl/pcie_symbol_lock_ctrl.sv
// Receive-lane symbol-lock controller: acquires lock on a run of COM symbols,
// tracks code errors while locked and pulses the SIPO reset to force re-search.
module pcie_symbol_lock_ctrl #(
  parameter int                    DATA_WIDTH     = 10,
  parameter logic [DATA_WIDTH-1:0] COMMA_RDN      = 10'b0011111010,
  parameter logic [DATA_WIDTH-1:0] COMMA_RDP      = 10'b1100000101,
  parameter int                    LOCK_COMMAS    = 4,
  parameter int                    ACQ_TIMEOUT    = 64,
  parameter int                    ERR_LIMIT      = 4,
  parameter int                    GOOD_RUN       = 16,
  parameter int                    REALIGN_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sipo_allign,
  input  logic [DATA_WIDTH-1:0]          sym_in,
  input  logic                           sym_valid,
  input  logic                           sym_err,
  output logic                           realign_req,
  output logic                           symbol_lock,
  output logic [$clog2(ERR_LIMIT+1)-1:0] err_cnt,
  output logic [7:0]                     lock_loss_cnt
);

  localparam int COM_W  = $clog2(LOCK_COMMAS + 1);
  localparam int ACQ_W  = $clog2(ACQ_TIMEOUT + 1);
  localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
  localparam int GOOD_W = $clog2(GOOD_RUN + 1);
  localparam int RL_W   = $clog2(REALIGN_CYCLES + 1);

  localparam logic [COM_W-1:0]  COM_LAST  = COM_W'(LOCK_COMMAS - 1);
  localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(ACQ_TIMEOUT - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LIMIT - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_RUN - 1);
  localparam logic [RL_W-1:0]   RL_LAST   = RL_W'(REALIGN_CYCLES - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    REALIGN  = 2'd3
  } state_t;

  state_t              state, next_state;
  logic [COM_W-1:0]    com_cnt, com_nxt;
  logic [ACQ_W-1:0]    acq_cnt, acq_nxt;
  logic [GOOD_W-1:0]   good_cnt, good_nxt;
  logic [RL_W-1:0]     rl_cnt, rl_nxt;
  logic [ERR_W-1:0]    err_nxt;
  logic [7:0]          loss_nxt;
  logic                sym_evt;
  logic                is_com;

  assign sym_evt = sym_valid & sipo_allign;
  assign is_com  = (sym_in == COMMA_RDN) || (sym_in == COMMA_RDP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= UNLOCKED;
    else          state <= next_state;
  end

  // Loss of SIPO alignment outranks any same-cycle symbol, errors included.
  always_comb begin
    next_state = state;
    case (state)
      UNLOCKED: if (sipo_allign) next_state = ACQUIRE;
      ACQUIRE: begin
        if (!sipo_allign) next_state = UNLOCKED;
        else if (sym_evt) begin
          if (sym_err)                   next_state = REALIGN;
          else if (is_com) begin
            if (com_cnt == COM_LAST)     next_state = LOCKED;
          end else if (acq_cnt == ACQ_LAST) next_state = REALIGN;
        end
      end
      LOCKED: begin
        if (!sipo_allign) next_state = UNLOCKED;
        else if (sym_evt && sym_err && (err_cnt == ERR_LAST)) next_state = REALIGN;
      end
      REALIGN: if (rl_cnt == RL_LAST) next_state = UNLOCKED;
      default: next_state = UNLOCKED;
    endcase
  end

  // Every state change starts the new state with clean counters.
  always_comb begin
    com_nxt  = com_cnt;
    acq_nxt  = acq_cnt;
    good_nxt = good_cnt;
    err_nxt  = err_cnt;
    rl_nxt   = '0;
    loss_nxt = lock_loss_cnt;
    if (next_state != state) begin
      com_nxt  = '0;
      acq_nxt  = '0;
      good_nxt = '0;
      err_nxt  = '0;
    end else begin
      case (state)
        ACQUIRE: if (sym_evt) begin
          if (is_com) begin
            com_nxt = com_cnt + 1'b1;
            acq_nxt = '0;
          end else begin
            acq_nxt = acq_cnt + 1'b1;
          end
        end
        LOCKED: if (sym_evt) begin
          if (sym_err) begin
            err_nxt  = err_cnt + 1'b1;
            good_nxt = '0;
          end else if (good_cnt == GOOD_LAST) begin
            good_nxt = '0;
            if (err_cnt != '0) err_nxt = err_cnt - 1'b1;
          end else begin
            good_nxt = good_cnt + 1'b1;
          end
        end
        REALIGN: rl_nxt = rl_cnt + 1'b1;
        default: ;
      endcase
    end
    if ((state == LOCKED) && (next_state != LOCKED) && (lock_loss_cnt != 8'hFF))
      loss_nxt = lock_loss_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      com_cnt       <= '0;
      acq_cnt       <= '0;
      good_cnt      <= '0;
      rl_cnt        <= '0;
      err_cnt       <= '0;
      lock_loss_cnt <= '0;
      symbol_lock   <= 1'b0;
      realign_req   <= 1'b0;
    end else begin
      com_cnt       <= com_nxt;
      acq_cnt       <= acq_nxt;
      good_cnt      <= good_nxt;
      rl_cnt        <= rl_nxt;
      err_cnt       <= err_nxt;
      lock_loss_cnt <= loss_nxt;
      symbol_lock   <= (next_state == LOCKED);
      realign_req   <= (next_state == REALIGN);
    end
  end

endmodule
